// File: rtl/timer_bank.sv
// timer_bank: N_CH independent programmable down-counters with one-shot or
// auto-reload mode, a per-channel interrupt mask and a sticky pending flag.
// Register map: addr[3:2] = channel, addr[1:0] = 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved.
module timer_bank #(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      addr,
  input  logic            we,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  output logic [N_CH-1:0] irq
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  logic [CNT_W-1:0] preset_a [N_CH];
  logic [CNT_W-1:0] count_a  [N_CH];
  logic [N_CH-1:0]  en_v;
  logic [N_CH-1:0]  mode_v;
  logic [N_CH-1:0]  im_v;
  logic [N_CH-1:0]  pend_v;

  // Write data bits above CNT_W are don't-care for the narrower configurations.
  logic unused_wd;
  assign unused_wd = ^wd;

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] preset_q;
    logic [CNT_W-1:0] count_q;
    logic             en_q;
    logic             mode_q;
    logic             im_q;
    logic             pend_q;
    logic             wr_sel;
    logic             wr_ctrl;
    logic             wr_preset;
    logic             stop;
    logic             set_pend;

    assign wr_sel    = we && (addr[3:2] == 2'(i));
    assign wr_ctrl   = wr_sel && (addr[1:0] == REG_CTRL);
    assign wr_preset = wr_sel && (addr[1:0] == REG_PRESET);
    // A CTRL write with en = 0 aborts the channel and suppresses any terminal event.
    assign stop      = wr_ctrl && !wd[0];
    assign set_pend  = !stop &&
                       (((state == ST_LOAD) && (preset_q == '0)) ||
                        ((state == ST_CNT)  && (count_q <= CNT_W'(1))));

    // Channel control bits and IDLE/LOAD/CNT/INT sequencing of the counter.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= ST_IDLE;
        count_q <= '0;
        en_q    <= 1'b0;
        mode_q  <= 1'b0;
        im_q    <= 1'b0;
      end else begin
        if (wr_ctrl) begin
          en_q   <= wd[0];
          mode_q <= wd[1];
          im_q   <= wd[2];
        end
        if (stop) begin
          state <= ST_IDLE;
        end else begin
          case (state)
            ST_IDLE: begin
              if (en_q) state <= ST_LOAD;
            end
            ST_LOAD: begin
              count_q <= preset_q;
              state   <= (preset_q == '0) ? ST_INT : ST_CNT;
            end
            ST_CNT: begin
              if (count_q > CNT_W'(1)) begin
                count_q <= count_q - CNT_W'(1);
              end else begin
                count_q <= '0;
                state   <= ST_INT;
              end
            end
            ST_INT: begin
              if (mode_q) begin
                state <= ST_LOAD;
              end else begin
                state <= ST_IDLE;
                en_q  <= 1'b0;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end

    // Preset register; only sampled by the counter on a LOAD edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        preset_q <= '0;
      end else if (wr_preset) begin
        preset_q <= wd[CNT_W-1:0];
      end
    end

    // Sticky pending flag: write-1-to-clear, with a same-edge set taking priority.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_q <= 1'b0;
      end else begin
        pend_q <= set_pend | (pend_q & ~(wr_ctrl & wd[3]));
      end
    end

    assign preset_a[i] = preset_q;
    assign count_a[i]  = count_q;
    assign en_v[i]     = en_q;
    assign mode_v[i]   = mode_q;
    assign im_v[i]     = im_q;
    assign pend_v[i]   = pend_q;
  end

  // Combinational read mux; unimplemented channels and the reserved slot read 0.
  always_comb begin
    rd = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (addr[3:2] == 2'(i)) begin
        case (addr[1:0])
          REG_CTRL:   rd = {28'd0, pend_v[i], im_v[i], mode_v[i], en_v[i]};
          REG_PRESET: rd = 32'(preset_a[i]);
          REG_COUNT:  rd = 32'(count_a[i]);
          default:    rd = '0;
        endcase
      end
    end
  end

  assign irq = pend_v & im_v;

endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised multi-channel programmable timer for the bridge-attached device space: N_CH independent down-counters, each with one-shot or auto-reload mode, a per-channel interrupt mask and a sticky pending flag. It succeeds the single-channel timer and drives one hwint line per channel into cp0. The bridge supplies a word address, write enable and write data, and reads back through a combinational `rd`.

## Interface

**Parameters**
- `N_CH`, 2: number of channels; legal range 1..4.
- `CNT_W`, 32: counter and preset width; legal range 1..32.

**Ports**
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `addr`  in  4: word address. `addr[3:2]` selects the channel, `addr[1:0]` selects the register: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `we`  in  1: write strobe, sampled at the clock edge.
- `wd`  in  32: write data.
- `rd`  out  32: read data, combinational from `addr`.
- `irq`  out  N_CH: per-channel interrupt, `irq[i] = pend[i] & im[i]`.

## Operation

**Per-channel registers**
- CTRL bit 0 `en`: enable.
- CTRL bit 1 `mode`: 0 = one-shot, 1 = auto-reload.
- CTRL bit 2 `im`: interrupt mask (1 = allowed).
- CTRL bit 3 `pend`: pending flag, read-only; writing 1 clears it (W1C).
- CTRL bits 31:4 read as 0.
- PRESET: read/write, CNT_W bits.
- COUNT: read-only, CNT_W bits.
- Reads are zero-extended to 32 bits. Write bits above CNT_W are ignored.
- Writes to COUNT, to the reserved register, or to channel ≥ N_CH are ignored; reads of these return 0.

**Per-channel FSM** (states IDLE, LOAD, CNT, INT)
- IDLE: if `en`, go to LOAD.
- LOAD: COUNT ← PRESET.
  - PRESET ≠ 0: go to CNT.
  - PRESET = 0: go to INT and set `pend` on the same edge.
- CNT:
  - COUNT > 1: decrement.
  - COUNT = 1: COUNT ← 0, go to INT, set `pend` on the same edge.
- INT (lasts one cycle):
  - mode 0: clear `en`, go to IDLE.
  - mode 1: go to LOAD.
- A CTRL write with `en` = 0, in any state, forces IDLE at that edge. COUNT holds its value and `pend` is untouched.
- A CTRL write with `en` = 1 while in LOAD, CNT or INT does not restart the channel. Only `mode` and `im` update.
- A PRESET write during counting does not affect COUNT. It takes effect at the next LOAD.
- If `pend` is set and cleared on the same edge, set wins.
- Channels are fully independent. No write touches more than one channel.

## Timing

- Reset: every CTRL, PRESET and COUNT is 0; every FSM is in IDLE; `irq` = 0; `rd` = 0 for all addresses.
- Reset asserted mid-count returns the channel to the reset state immediately, without waiting for a clock edge.
- Latency, with the CTRL write (`en` = 1) at edge E0 and PRESET = P ≥ 1:
  - E1: enter LOAD.
  - E2: COUNT = P, enter CNT.
  - E(2+P): COUNT = 0, `pend` = 1, enter INT. `irq` is high after this edge if `im` = 1.
- PRESET = 0: `pend` sets at E2.
- Auto-reload period: P + 2 cycles between successive `pend` set edges.
- A written value is visible on `rd` in the cycle after the write edge.
- `irq` responds combinationally to `im` and `pend`.

## Test plan

1. **Reset:** assert `rst` asynchronously mid-cycle during count → all reads 0 and `irq` = 0 immediately; no activity until a new CTRL write.
2. **One-shot:** ch0 PRESET = 5, CTRL = 0x5 at E0 → COUNT reads 5 after E2 and 1 after E6; `irq[0]` rises after E7; COUNT stays 0, `en` reads 0, state stays IDLE; `irq[0]` remains high until CTRL is written with bit 3 = 1.
3. **Auto-reload plus W1C:** ch1 PRESET = 3, CTRL = 0x3 (masked) → `pend` sets every 5 cycles while `irq[1]` stays 0. Set `im` → `irq[1]` rises in the next cycle. A W1C write on an edge where `pend` would also set → `pend` stays 1.
4. **Disable mid-count:** ch0 PRESET = 10, enable; write CTRL = 0 when COUNT = 6 → COUNT holds 6 and no `irq`. Re-enable → COUNT reloads to 10 two edges later.
5. **Widths and ranges:** with N_CH = 2, CNT_W = 8: PRESET write 0x1FF reads back 0xFF; writes to addr 0x8–0xF are ignored and read 0. Two channels running concurrently with P = 2 and P = 4 → independent `irq` timing (4 and 6 cycle periods).
6. **Zero preset:** PRESET = 0, one-shot → `pend` sets at E2 and the channel returns to IDLE at E3.
